pwm_leg_deadtime: RTL

Consumer of the triangle carrier: converts the carrier count and a commanded duty into one inverter leg's complementary gate pair (gate_hi/gate_lo) with programmable dead time. Duty and dead time are double-buffered and take effect only at carrier valley (and optionally peak) events, so a mid-period register write never produces a glitch. One instance per inverter leg; all legs share one carrier generator.

---
 rtl/pwm_leg_deadtime.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pwm_leg_deadtime.sv
// One inverter leg: compares the shared triangle carrier against a double-buffered duty
// and drives a complementary gate pair with a programmable dead-time gap.
module pwm_leg_deadtime #(
  parameter int CARRIER_W = 16,
  parameter int DT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CARRIER_W-1:0] carrier,
  input  logic                 carrier_high,
  input  logic                 carrier_low,
  input  logic [CARRIER_W-1:0] duty,
  input  logic [DT_W-1:0]      deadtime,
  input  logic                 update_both,
  input  logic                 enable,
  output logic                 gate_hi,
  output logic                 gate_lo,
  output logic                 pwm_raw,
  output logic [CARRIER_W-1:0] duty_active
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DT_TO_HI = 3'd1;
  localparam logic [2:0] ST_HI       = 3'd2;
  localparam logic [2:0] ST_DT_TO_LO = 3'd3;
  localparam logic [2:0] ST_LO       = 3'd4;

  logic [CARRIER_W-1:0] duty_active_q, duty_active_d;
  logic [DT_W-1:0]      dt_active_q, dt_active_d;
  logic [DT_W-1:0]      dt_cnt_q, dt_cnt_d;
  logic [2:0]           state_q, state_d;
  logic                 pwm_raw_q, pwm_raw_d;
  logic                 gate_hi_q, gate_hi_d;
  logic                 gate_lo_q, gate_lo_d;
  logic                 shadow_load;

  always_comb begin
    shadow_load   = carrier_low | (carrier_high & update_both);
    duty_active_d = shadow_load ? duty : duty_active_q;
    dt_active_d   = shadow_load ? deadtime : dt_active_q;
    pwm_raw_d     = (carrier < duty_active_q);
  end

  // The DT states leave when the count reaches 1 so the both-off gap is exactly
  // dt_active cycles; a zero dead time bypasses the DT states altogether.
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    if (!enable) begin
      state_d  = ST_IDLE;
      dt_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dt_cnt_d = dt_active_q;
          if (pwm_raw_q) state_d = (dt_active_q == '0) ? ST_HI : ST_DT_TO_HI;
          else           state_d = (dt_active_q == '0) ? ST_LO : ST_DT_TO_LO;
        end
        ST_HI: begin
          if (!pwm_raw_q) begin
            dt_cnt_d = dt_active_q;
            state_d  = (dt_active_q == '0) ? ST_LO : ST_DT_TO_LO;
          end
        end
        ST_LO: begin
          if (pwm_raw_q) begin
            dt_cnt_d = dt_active_q;
            state_d  = (dt_active_q == '0) ? ST_HI : ST_DT_TO_HI;
          end
        end
        ST_DT_TO_HI: begin
          // Compare reverted before gate_hi ever rose: low side is safe to re-enter at once.
          if (!pwm_raw_q) begin
            state_d  = ST_LO;
            dt_cnt_d = '0;
          end else if (dt_cnt_q <= DT_W'(1)) begin
            state_d  = ST_HI;
            dt_cnt_d = '0;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_W'(1);
          end
        end
        ST_DT_TO_LO: begin
          if (pwm_raw_q) begin
            state_d  = ST_HI;
            dt_cnt_d = '0;
          end else if (dt_cnt_q <= DT_W'(1)) begin
            state_d  = ST_LO;
            dt_cnt_d = '0;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_W'(1);
          end
        end
        default: begin
          state_d  = ST_IDLE;
          dt_cnt_d = '0;
        end
      endcase
    end
    gate_hi_d = (state_d == ST_HI);
    gate_lo_d = (state_d == ST_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_active_q <= '0;
      dt_active_q   <= '0;
      dt_cnt_q      <= '0;
      state_q       <= ST_IDLE;
      pwm_raw_q     <= 1'b0;
      gate_hi_q     <= 1'b0;
      gate_lo_q     <= 1'b0;
    end else begin
      duty_active_q <= duty_active_d;
      dt_active_q   <= dt_active_d;
      dt_cnt_q      <= dt_cnt_d;
      state_q       <= state_d;
      pwm_raw_q     <= pwm_raw_d;
      gate_hi_q     <= gate_hi_d;
      gate_lo_q     <= gate_lo_d;
    end
  end

  assign gate_hi     = gate_hi_q;
  assign gate_lo     = gate_lo_q;
  assign pwm_raw     = pwm_raw_q;
  assign duty_active = duty_active_q;

endmodule
